// File: rtl/pll_csr_bank_if.sv
// CSR host bus for the PLL configuration bank.
// Latency: read data and error pulse are returned one cycle after the strobe.
// Backpressure: none; the slave accepts one access every cycle.
//
// Signals: csr_we/csr_re strobes, csr_addr {page,reg}, csr_wdata,
//          csr_rdata/csr_rvalid registered read return, csr_err illegal-access pulse.
interface pll_csr_bank_if;
  logic       csr_we;
  logic       csr_re;
  logic [7:0] csr_addr;
  logic [7:0] csr_wdata;
  logic [7:0] csr_rdata;
  logic       csr_rvalid;
  logic       csr_err;

  modport master (
    output csr_we, csr_re, csr_addr, csr_wdata,
    input  csr_rdata, csr_rvalid, csr_err
  );

  modport slave (
    input  csr_we, csr_re, csr_addr, csr_wdata,
    output csr_rdata, csr_rvalid, csr_err
  );
endinterface

// File: rtl/pll_csr_bank.sv
// Double-buffered PLL configuration bank: host writes shadow, COMMIT copies
// shadow to active per channel mask. Latency: reads/err 1 cycle, commit 1 edge.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports: clk, rst_n (async active-low), csr (pll_csr_bank_if.slave),
//        div_fb/div_out/ref_sel/enb active per-channel fields, ready settle status.
// Optional macro PLL_CSR_SETTLE_EN: per-channel settle counters drive ready;
// without it ready is constant all ones.
module pll_csr_bank #(
  parameter int NCH        = 4,
  parameter int DIVW       = 4,
  parameter int SELW       = 2,
  parameter int SETTLE_CYC = 16,
  parameter int CNTW       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pll_csr_bank_if.slave        csr,
  output logic [NCH*DIVW-1:0]  div_fb,
  output logic [NCH*DIVW-1:0]  div_out,
  output logic [NCH*SELW-1:0]  ref_sel,
  output logic [NCH-1:0]       enb,
  output logic [NCH-1:0]       ready
);

  // Elaboration-time guard on parameter combinations that cannot work.
  if (NCH < 2 || NCH > 8 || (1 << SELW) < NCH || SETTLE_CYC < 1 ||
      SETTLE_CYC >= (1 << CNTW)) begin : g_param_bad
    $error("pll_csr_bank: illegal parameter combination");
  end

  localparam logic [3:0] NCH4 = 4'(NCH);
  localparam logic [7:0] NCH8 = 8'(NCH);

  logic [NCH-1:0][DIVW-1:0] sh_fb_q,  sh_fb_d,  act_fb_q,  act_fb_d;
  logic [NCH-1:0][DIVW-1:0] sh_out_q, sh_out_d, act_out_q, act_out_d;
  logic [NCH-1:0][SELW-1:0] sh_sel_q, sh_sel_d, act_sel_q, act_sel_d;
  logic [NCH-1:0]           sh_enb_q, sh_enb_d, act_enb_q, act_enb_d;

  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       err_q, err_d;

  logic [3:0] page, rsel;
  logic       is_ch, is_glb, ch_reg_ok;
  logic       ref_bad, wr_commit, wr_err, rd_ok, rd_err;
  logic [DIVW-1:0] div_val;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  commit_mask;
  logic [NCH-1:0]  ready_w;

  assign page      = csr.csr_addr[7:4];
  assign rsel      = csr.csr_addr[3:0];
  assign is_ch     = (page < NCH4);
  assign is_glb    = (page == 4'hF);
  assign ch_reg_ok = is_ch && (rsel < 4'd4);

  // ref_sel is checked against the whole byte so high garbage bits cannot alias
  // onto a legal select.
  assign ref_bad   = (rsel == 4'd2) && (csr.csr_wdata >= NCH8);
  assign wr_commit = csr.csr_we && is_glb && (rsel == 4'd0);
  assign wr_err    = csr.csr_we &&
                     (!(ch_reg_ok || (is_glb && rsel == 4'd0)) || (ch_reg_ok && ref_bad));
  assign rd_ok     = csr.csr_re &&
                     (ch_reg_ok || (is_glb && (rsel == 4'd1 || rsel == 4'd2)));
  assign rd_err    = csr.csr_re && !rd_ok;

  // A zero divider would stall the PLL; it is promoted to divide-by-one.
  assign div_val     = (csr.csr_wdata[DIVW-1:0] == '0) ? DIVW'(1) : csr.csr_wdata[DIVW-1:0];
  assign commit_mask = wr_commit ? csr.csr_wdata[NCH-1:0] : '0;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pending[i] = (sh_fb_q[i]  != act_fb_q[i])  || (sh_out_q[i] != act_out_q[i]) ||
                   (sh_sel_q[i] != act_sel_q[i]) || (sh_enb_q[i] != act_enb_q[i]);
    end
  end

  always_comb begin
    sh_fb_d   = sh_fb_q;
    sh_out_d  = sh_out_q;
    sh_sel_d  = sh_sel_q;
    sh_enb_d  = sh_enb_q;
    act_fb_d  = act_fb_q;
    act_out_d = act_out_q;
    act_sel_d = act_sel_q;
    act_enb_d = act_enb_q;
    for (int i = 0; i < NCH; i++) begin
      if (csr.csr_we && ch_reg_ok && page == 4'(i)) begin
        case (rsel)
          4'd0:    sh_fb_d[i]  = div_val;
          4'd1:    sh_out_d[i] = div_val;
          4'd2:    if (!ref_bad) sh_sel_d[i] = csr.csr_wdata[SELW-1:0];
          4'd3:    sh_enb_d[i] = csr.csr_wdata[0];
          default: ;
        endcase
      end
      if (commit_mask[i]) begin
        act_fb_d[i]  = sh_fb_q[i];
        act_out_d[i] = sh_out_q[i];
        act_sel_d[i] = sh_sel_q[i];
        act_enb_d[i] = sh_enb_q[i];
      end
    end
  end

  // Read path uses the _q values, so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d  = 8'h00;
    rvalid_d = csr.csr_re;
    err_d    = wr_err || rd_err;
    if (rd_ok) begin
      if (is_glb) begin
        rdata_d = (rsel == 4'd1) ? 8'(ready_w) : 8'(pending);
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (page == 4'(i)) begin
            case (rsel)
              4'd0:    rdata_d = 8'(sh_fb_q[i]);
              4'd1:    rdata_d = 8'(sh_out_q[i]);
              4'd2:    rdata_d = 8'(sh_sel_q[i]);
              4'd3:    rdata_d = 8'(sh_enb_q[i]);
              default: rdata_d = 8'h00;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sh_fb_q[i]   <= DIVW'(1);
        sh_out_q[i]  <= DIVW'(1);
        act_fb_q[i]  <= DIVW'(1);
        act_out_q[i] <= DIVW'(1);
      end
      sh_sel_q  <= '0;
      act_sel_q <= '0;
      sh_enb_q  <= '1;
      act_enb_q <= '1;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sh_fb_q   <= sh_fb_d;
      sh_out_q  <= sh_out_d;
      sh_sel_q  <= sh_sel_d;
      sh_enb_q  <= sh_enb_d;
      act_fb_q  <= act_fb_d;
      act_out_q <= act_out_d;
      act_sel_q <= act_sel_d;
      act_enb_q <= act_enb_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

`ifdef PLL_CSR_SETTLE_EN
  localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_CYC);

  logic [NCH-1:0][CNTW-1:0] cnt_q, cnt_d;

  // Counter loads on the commit edge, so ready falls together with the active
  // update and returns after SETTLE_CYC further edges. Re-commit reloads.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = (cnt_q[i] != '0) ? cnt_q[i] - CNTW'(1) : '0;
      if (commit_mask[i]) cnt_d[i] = SETTLE_LD;
      ready_w[i] = (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign ready_w = '1;
`endif

  assign div_fb         = act_fb_q;
  assign div_out        = act_out_q;
  assign ref_sel        = act_sel_q;
  assign enb            = act_enb_q;
  assign ready          = ready_w;
  assign csr.csr_rdata  = rdata_q;
  assign csr.csr_rvalid = rvalid_q;
  assign csr.csr_err    = err_q;

endmodule

// File: doc/pll_csr_bank.md
Name: pll_csr_bank

Overview:
- Parametrised, double-buffered configuration register bank for the multi-channel PLL macro.
- Replaces the flat nibble-addressed register set.
- Host writes land in shadow registers. An explicit commit copies them atomically, per channel, into the active registers that drive the PLL divider, reference-select and enable pins.
- An optional settle timer reports per-channel lock readiness after each commit.

Parameters:
- NCH, 4, number of PLL channels (2..8)
- DIVW, 4, divider field width (fb and out)
- SELW, 2, reference-select field width; must satisfy 2^SELW >= NCH
- SETTLE_CYC, 16, clk cycles a channel is held not-ready after a commit
- CNTW, 5, settle counter width; must hold SETTLE_CYC

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- csr_we  in  1  write strobe, one write per cycle
- csr_re  in  1  read strobe
- csr_addr  in  8  [7:4] = page (channel 0..NCH-1, or 0xF = global); [3:0] = register
- csr_wdata  in  8  write data; fields use the LSBs
- csr_rdata  out  8  read data, registered
- csr_rvalid  out  1  one-cycle pulse accompanying csr_rdata
- csr_err  out  1  one-cycle pulse on an illegal access
- div_fb  out  NCH*DIVW  active feedback dividers, channel i at [i*DIVW +: DIVW]
- div_out  out  NCH*DIVW  active output dividers
- ref_sel  out  NCH*SELW  active reference selects
- enb  out  NCH  active disable bits (1 = channel off)
- ready  out  NCH  channel settled since its last commit

Behaviour:
- Reset (async assert, sync release):
  - shadow and active div_fb/div_out = 1
  - ref_sel = 0, enb = all 1s, ready = all 1s
  - csr_rdata = 0, csr_rvalid = 0, csr_err = 0, counters = 0
  - Reset mid-settle aborts the timer.
- Channel page registers: 0 = div_fb, 1 = div_out, 2 = ref_sel, 3 = enb (bit 0).
- Global page registers:
  - 0xF0 = COMMIT (write only, data[NCH-1:0] = channel mask)
  - 0xF1 = READY (read only)
  - 0xF2 = PENDING (read only; bit i = shadow != active for channel i)
- Writes go to shadow only. Active outputs are unaffected until commit.
- Writing 0 to div_fb or div_out stores 1; divide-by-zero is illegal.
- A ref_sel write with value >= NCH is ignored and pulses csr_err next cycle.
- Illegal accesses pulse csr_err the following cycle and modify nothing:
  - page >= NCH and != 0xF
  - unmapped register
  - write to 0xF1 or 0xF2
  - read of 0xF0
- COMMIT with mask m: on the next rising edge, active[i] <= shadow[i] for every set bit i. Unmasked channels are untouched.
- A mask of 0 is legal and does nothing.
- Read latency is 1 cycle:
  - csr_rdata/csr_rvalid are registered from the address sampled with csr_re.
  - Channel registers return shadow values, zero-extended.
  - An illegal read returns 0x00 with csr_rvalid=1 and csr_err=1.
- Simultaneous csr_we and csr_re in one cycle: both are performed; the read returns the pre-write value.
- A write to a shadow register in the same cycle as a COMMIT cannot occur, because there is one address per cycle.

Optional Feature:
- Macro: PLL_CSR_SETTLE_EN
- Defined:
  - Per-channel down-counter loads SETTLE_CYC on commit of that channel; ready[i]=0 while the counter is non-zero.
  - ready[i] drops on the same edge that updates active[i] and rises exactly SETTLE_CYC cycles later.
  - Re-commit while settling reloads the counter.
- Undefined:
  - No counters are instantiated; ready is constant all 1s.
  - Reading 0xF1 returns {(8-NCH) zeros, NCH ones}.

Test Plan:
1. Reset, then read 0x00, 0x01, 0x02, 0x03 -> rdata 0x01, 0x01, 0x00, 0x01 each with rvalid one cycle after re; div_fb = 0x1111, enb = 4'b1111.
2. Write 0x10<=0x7, then read 0xF2 -> rdata 0x02 and div_fb[7:4] still 1. Then write 0xF0<=0x02 -> next edge div_fb[7:4]=7; 0xF2 reads 0x00.
3. Write 0x20<=0x0 and commit 0x04 -> div_fb[11:8]=1. Write 0x32<=0x5 -> csr_err pulse; shadow ref_sel ch3 stays 0.
4. Writes 0x50 (page 5 with NCH=4) and 0xF1, and read of 0xF0 -> csr_err pulse each; read returns 0x00 with rvalid=1; no state change.
5. With PLL_CSR_SETTLE_EN: commit 0x01 -> ready[0]=0 for exactly 16 cycles. Re-commit at cycle 10 -> ready[0] stays low 16 more cycles. Assert rst_n=0 mid-count -> ready=all 1s immediately.
6. Same-cycle csr_we and csr_re to 0x11 with old value 3 and new value 9 -> rdata=0x03; a read next cycle returns 0x09.
